ad9228_trigger_capture: RTL and testbench
=========================================

// Module: ad9228_trigger_capture
// PURPOSE
//  Consumes the per-channel deserialized ADC word, which is stable for one full sampling period, in the sampling-clock domain.
//  Continuously records samples into a ring buffer and fires on a threshold crossing or a software trigger.
//  Freezes a pre/post-trigger window, then streams it out on a valid/ready interface toward the readout DMA/AXIS path.
// PARAMETERS
//  DATA_WIDTH  12  sample width; matches deserializer output
//  DEPTH       16  ring-buffer depth in samples; power of 2, >= 4
//  ADDR_W      $clog2(DEPTH)  derived; do not override
// PORTS
//  clk             in   1           sampling clock (ADC conversion clock)
//  rstn            in   1           reset; synchronous, active-low
//  des_data        in   DATA_WIDTH  deserialized sample; changes once per clk period
//  arm             in   1           pulse: start acquisition (honoured only in IDLE)
//  abort           in   1           pulse: return to IDLE from any state
//  sw_trig         in   1           pulse: force trigger (honoured only in WAIT_TRIG)
//  trig_rising     in   1           1 = rising-edge threshold, 0 = falling-edge threshold
//  trig_threshold  in   DATA_WIDTH  trigger level
//  pre_samples     in   ADDR_W      samples kept before the trigger sample
//  post_samples    in   ADDR_W      samples kept after the trigger sample
//  m_data          out  DATA_WIDTH  readout sample
//  m_valid         out  1           readout valid
//  m_ready         in   1           readout ready
//  m_last          out  1           marks the final sample of the window
//  busy            out  1           high in every state except IDLE
//  done            out  1           one-cycle pulse when the m_last beat is accepted
// BEHAVIOUR
//  - Reset (rstn=0 at posedge clk): state=IDLE, all pointers and counters 0.
//    Outputs m_valid, m_last, busy, done and m_data are all 0. RAM contents are don't-care.
//  - Input path: des_data -> s1 -> s2, two flops, clk domain. x[n]=s2; latency des_data->x is 2 clk.
//    prev = x[n-1], registered.
//  - Window parameters are latched on arm: P=pre_samples, Q=post_samples.
//    If P+Q > DEPTH-1, then Q := DEPTH-1-P. Window length L=P+1+Q.
//  - FSM IDLE -> PRETRIG -> WAIT_TRIG -> POSTTRIG -> READOUT -> IDLE.
//  - IDLE: no writes. On arm: wr_ptr=0, cnt=0, go to PRETRIG; go directly to WAIT_TRIG if P==0.
//  - PRETRIG: write x to RAM[wr_ptr] every cycle, wr_ptr+1 mod DEPTH.
//    Once P samples are written, go to WAIT_TRIG. Triggers are ignored in this state.
//  - WAIT_TRIG: keep writing every cycle; the ring wraps freely.
//    Trigger condition:
//      rising:  prev <  thr && x >= thr
//      falling: prev >  thr && x <= thr
//      or sw_trig
//    Coincident sources produce one trigger. The sample written in the trigger cycle is the trigger sample.
//    trig_ptr = its address. Go to POSTTRIG, or to READOUT if Q==0.
//  - POSTTRIG: write Q further samples, then go to READOUT. Writes stop after the last one.
//  - READOUT: rd_ptr starts at trig_ptr-P mod DEPTH and emits L beats in time order.
//    A beat transfers on m_valid && m_ready. m_last=1 on beat L-1 only.
//    While m_ready=0, m_data/m_valid/m_last hold stable; no drops or duplicates.
//    After the last beat is accepted: done pulses for 1 cycle, state -> IDLE.
//    m_valid is 0 in the first READOUT cycle (RAM prefetch).
//  - abort: any state -> IDLE on the next cycle; m_valid/m_last drop to 0 and done is not asserted.
//    If abort and arm coincide, abort wins.
//  - arm outside IDLE is ignored. sw_trig outside WAIT_TRIG is ignored.
//  - rstn deassertion mid-window discards the capture; no partial readout.
//  - Comparisons are unsigned unless the macro below is defined.
// CONFIGURATION
//  - ADC_CAPTURE_TWOS_COMP_EN defined: x = {~s2[MSB], s2[MSB-1:0]}, converting offset-binary to two's complement.
//    The threshold comparison is signed, and stored/streamed samples are two's complement.
//  - Not defined: raw offset-binary samples; unsigned comparison.
// STRUCTURE
//  - Package ad9228_capture_pkg:
//    capture_state_e {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, READOUT}
//    DEFAULT_DATA_WIDTH=12, DEFAULT_DEPTH=16
//  - Sub-module ad9228_capture_ram: simple dual-port, 1 write / 1 read port, registered read (1-clk latency).
//  - Top holds the FSM, counters, trigger comparator and a 1-entry output skid register.
// TESTING  (DATA_WIDTH=12, DEPTH=16)
//  1. rstn=0 for 3 clk with random inputs -> m_valid=0, m_last=0, busy=0, done=0; state IDLE.
//  2. Ramp des_data=n, P=4, Q=3, rising, thr=100, arm well before the ramp reaches 100
//     -> 8 beats 96..103, m_last on 103, done pulse, busy=0.
//  3. Ramp down from 200, falling, thr=150, P=2, Q=2 -> beats 152,151,150,149,148.
//     Repeat with thr=4095 and sw_trig -> trigger sample = value at the sw_trig cycle.
//  4. Case 2 with m_ready pattern 1,0,1,0,0,1... -> exactly 96..103 in order, data stable while stalled.
//  5. P=10, Q=10 -> Q clamped to 5, 16 beats. Abort during POSTTRIG -> IDLE next clk, m_valid=0, no done; re-arm completes.
//  6. ADC_CAPTURE_TWOS_COMP_EN: des_data 0x7FF->0x800 with thr=0, rising -> trigger fires; beats 0xFFF, 0x000.

Source files
------------

// File: rtl/ad9228_capture_pkg.sv
// Shared types, defaults and window-sizing helper for the AD9228 trigger/capture slice.
package ad9228_capture_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRETRIG   = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTTRIG  = 3'd3,
        READOUT   = 3'd4
    } capture_state_e;

    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int DEFAULT_DEPTH      = 16;

    // Limit the post-trigger count so pre + trigger + post never exceeds the ring.
    function automatic int clamp_post(input int pre, input int post, input int depth);
        int limit;
        limit = depth - 1 - pre;
        if (post > limit) begin
            return limit;
        end else begin
            return post;
        end
    endfunction

endpackage

// File: rtl/ad9228_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port that
// holds its output while the read enable is low.
module ad9228_capture_ram
    import ad9228_capture_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH      = DEFAULT_DEPTH,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage write and registered read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ad9228_trigger_capture.sv
// Ring-buffer trigger capture for one AD9228 channel with valid/ready window readout.
// Define ADC_CAPTURE_TWOS_COMP_EN to convert samples to two's complement and compare signed.
module ad9228_trigger_capture
    import ad9228_capture_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH      = DEFAULT_DEPTH,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] des_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  sw_trig,
    input  logic                  trig_rising,
    input  logic [DATA_WIDTH-1:0] trig_threshold,
    input  logic [ADDR_W-1:0]     pre_samples,
    input  logic [ADDR_W-1:0]     post_samples,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

    capture_state_e        r_state;
    capture_state_e        w_next;

    logic [DATA_WIDTH-1:0] r_s1;
    logic [DATA_WIDTH-1:0] r_s2;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] w_x;
    logic                  w_prev_lt;
    logic                  w_prev_gt;
    logic                  w_x_ge;
    logic                  w_x_le;
    logic                  w_trig;

    logic [ADDR_W-1:0]     w_post_clamped;
    logic [ADDR_W-1:0]     r_pre;
    logic [ADDR_W-1:0]     r_post;
    logic [ADDR_W:0]       r_len;
    logic [ADDR_W-1:0]     r_cnt;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_issued;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_trig_fire;
    logic                  w_out_load;
    logic                  w_last_acc;
    logic [DATA_WIDTH-1:0] w_ram_q;

    logic                  r_q_valid;
    logic                  r_q_last;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_valid;
    logic                  r_m_last;
    logic                  r_busy;
    logic                  r_done;

    // Two-flop input pipeline plus one-sample history for edge detection.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s1   <= {DATA_WIDTH{1'b0}};
            r_s2   <= {DATA_WIDTH{1'b0}};
            r_prev <= {DATA_WIDTH{1'b0}};
        end else begin
            r_s1   <= des_data;
            r_s2   <= r_s1;
            r_prev <= w_x;
        end
    end

`ifdef ADC_CAPTURE_TWOS_COMP_EN
    assign w_x       = {~r_s2[DATA_WIDTH-1], r_s2[DATA_WIDTH-2:0]};
    assign w_prev_lt = $signed(r_prev) <  $signed(trig_threshold);
    assign w_prev_gt = $signed(r_prev) >  $signed(trig_threshold);
    assign w_x_ge    = $signed(w_x)    >= $signed(trig_threshold);
    assign w_x_le    = $signed(w_x)    <= $signed(trig_threshold);
`else
    assign w_x       = r_s2;
    assign w_prev_lt = r_prev <  trig_threshold;
    assign w_prev_gt = r_prev >  trig_threshold;
    assign w_x_ge    = w_x    >= trig_threshold;
    assign w_x_le    = w_x    <= trig_threshold;
`endif

    assign w_trig = sw_trig || (trig_rising ? (w_prev_lt && w_x_ge) : (w_prev_gt && w_x_le));
    assign w_post_clamped = ADDR_W'(clamp_post(int'(pre_samples), int'(post_samples), DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides everything, including a coincident arm.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (arm) w_next = (pre_samples == PTR_ZERO) ? WAIT_TRIG : PRETRIG;
                           else     w_next = IDLE;
                PRETRIG:   if (r_cnt == r_pre - PTR_ONE) w_next = WAIT_TRIG;
                           else                          w_next = PRETRIG;
                WAIT_TRIG: if (w_trig) w_next = (r_post == PTR_ZERO) ? READOUT : POSTTRIG;
                           else        w_next = WAIT_TRIG;
                POSTTRIG:  if (r_cnt == r_post - PTR_ONE) w_next = READOUT;
                           else                           w_next = POSTTRIG;
                READOUT:   if (w_last_acc) w_next = IDLE;
                           else            w_next = READOUT;
                default:   w_next = IDLE;
            endcase
        end
    end

    // Per-state control decode for the RAM ports and readout pipeline.
    always_comb begin
        w_wr_en     = (r_state == PRETRIG) || (r_state == WAIT_TRIG) || (r_state == POSTTRIG);
        w_trig_fire = (r_state == WAIT_TRIG) && w_trig && !abort;
        w_out_load  = r_q_valid && (!r_m_valid || m_ready);
        w_last_acc  = r_m_valid && m_ready && r_m_last;
        w_rd_en     = (r_state == READOUT) && (r_issued < r_len) && (!r_q_valid || w_out_load);
    end

    // Window parameters latched on arm, and write-side pointer/counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pre    <= PTR_ZERO;
            r_post   <= PTR_ZERO;
            r_len    <= LEN_ZERO;
            r_cnt    <= PTR_ZERO;
            r_wr_ptr <= PTR_ZERO;
        end else if (abort) begin
            r_cnt    <= PTR_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_pre    <= pre_samples;
                        r_post   <= w_post_clamped;
                        r_len    <= {1'b0, pre_samples} + LEN_ONE + {1'b0, w_post_clamped};
                        r_cnt    <= PTR_ZERO;
                        r_wr_ptr <= PTR_ZERO;
                    end
                end
                PRETRIG: begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_cnt    <= (w_next == WAIT_TRIG) ? PTR_ZERO : r_cnt + PTR_ONE;
                end
                WAIT_TRIG: begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_cnt    <= PTR_ZERO;
                end
                POSTTRIG: begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_cnt    <= r_cnt + PTR_ONE;
                end
                default: begin
                    r_cnt    <= r_cnt;
                end
            endcase
        end
    end

    // Read pointer, RAM output stage and the output skid register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_ptr  <= PTR_ZERO;
            r_issued  <= LEN_ZERO;
            r_q_valid <= 1'b0;
            r_q_last  <= 1'b0;
            r_m_data  <= {DATA_WIDTH{1'b0}};
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (abort) begin
            r_q_valid <= 1'b0;
            r_q_last  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            // The oldest sample of the window sits P entries behind the trigger sample.
            if (w_trig_fire) begin
                r_rd_ptr <= r_wr_ptr - r_pre;
                r_issued <= LEN_ZERO;
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_issued <= r_issued + LEN_ONE;
            end

            if (w_rd_en) begin
                r_q_valid <= 1'b1;
                r_q_last  <= (r_issued == r_len - LEN_ONE);
            end else if (w_out_load) begin
                r_q_valid <= 1'b0;
            end

            if (w_out_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_ram_q;
                r_m_last  <= r_q_last;
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    // Registered status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= w_last_acc && !abort;
        end
    end

    ad9228_capture_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_x),
        .i_re    (w_rd_en),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_ad9228_trigger_capture.sv
// Scoreboard bench for ad9228_trigger_capture: expected window beats are queued
// when a capture is set up and compared as the DUT streams them out.
module tb_ad9228_trigger_capture;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk            = 1'b0;
    logic          rstn           = 1'b0;
    logic [DW-1:0] des_data       = 12'd0;
    logic          arm            = 1'b0;
    logic          abort          = 1'b0;
    logic          sw_trig        = 1'b0;
    logic          trig_rising    = 1'b1;
    logic [DW-1:0] trig_threshold = 12'd0;
    logic [AW-1:0] pre_samples    = 4'd0;
    logic [AW-1:0] post_samples   = 4'd0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready        = 1'b1;
    logic          m_last;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         mon_e;
    int            errors     = 0;
    int            checks     = 0;
    int            done_cnt   = 0;
    int            ramp_val   = 0;
    int            ramp_dir   = 0;
    int            cyc        = 0;
    bit            ready_mode = 1'b0;
    logic [5:0]    ready_pat  = 6'b100101;
    bit            hold_v     = 1'b0;
    logic [DW-1:0] hold_d     = 12'd0;
    logic          hold_l     = 1'b0;
    bit            done_prev  = 1'b0;

    always #5 clk = ~clk;

    ad9228_trigger_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .des_data       (des_data),
        .arm            (arm),
        .abort          (abort),
        .sw_trig        (sw_trig),
        .trig_rising    (trig_rising),
        .trig_threshold (trig_threshold),
        .pre_samples    (pre_samples),
        .post_samples   (post_samples),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .done           (done)
    );

    // Output monitor: pops the scoreboard on each accepted beat, checks stall stability and done width.
    always @(negedge clk) begin
        if (rstn) begin
            if (hold_v) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== hold_d || m_last !== hold_l) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                             m_valid, m_data, m_last, hold_d, hold_l);
                end
            end
            hold_v = 1'b0;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%h l=%b, expected no beat", m_data, m_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_data !== mon_e.d || m_last !== mon_e.l) begin
                        errors++;
                        $display("FAIL beat: got d=%h l=%b, expected d=%h l=%b", m_data, m_last, mon_e.d, mon_e.l);
                    end
                end
            end else if (m_valid === 1'b1) begin
                hold_v = 1'b1;
                hold_d = m_data;
                hold_l = m_last;
            end
            if (done_prev) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_width: got done=%b on second cycle, expected 0", done);
                end
            end
            done_prev = (done === 1'b1);
            if (done === 1'b1) done_cnt++;
        end else begin
            hold_v    = 1'b0;
            done_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ramp_val = ramp_val + ramp_dir;
        des_data = DW'(ramp_val);
        cyc++;
        if (ready_mode) m_ready = ready_pat[cyc % 6];
        else            m_ready = 1'b1;
    endtask

    // Window around trigger sample t on a ramp of slope d: oldest first, last flagged.
    task automatic push_window(input int t, input int d, input int p, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = DW'(t + (i - p) * d);
            b.l = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_until_done(input int base, input int budget, output bit ok);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        ok = (done_cnt != base);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            des_data       = DW'($urandom);
            arm            = 1'($urandom);
            abort          = 1'($urandom);
            sw_trig        = 1'($urandom);
            trig_rising    = 1'($urandom);
            trig_threshold = DW'($urandom);
            pre_samples    = AW'($urandom);
            post_samples   = AW'($urandom);
            m_ready        = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({m_valid, m_last, busy, done} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags: got v/l/busy/done=%b, expected 0000", {m_valid, m_last, busy, done});
            end
            checks++;
            if (m_data !== 12'd0) begin
                errors++;
                $display("FAIL reset_data: got %h, expected 000", m_data);
            end
        end
        @(posedge clk);
        #1;
        arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; m_ready = 1'b1;
        rstn = 1'b1;
    endtask

    task automatic test_rising_ramp();
        bit ok;
        int base;
        ramp_val = 0; ramp_dir = 1; ready_mode = 1'b0;
        trig_rising = 1'b1; trig_threshold = 12'd100; pre_samples = 4'd4; post_samples = 4'd3;
        repeat (40) step();
        push_window(100, 1, 4, 8);
        base = done_cnt;
        arm = 1'b1; step(); arm = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rise_busy: got %b, expected 1", busy); end
        run_until_done(base, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rise_timeout: got no done, expected done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rise_left: got %0d beats missing, expected 0", exp_q.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rise_idle: got busy=%b, expected 0", busy); end
        exp_q.delete();
    endtask

    task automatic test_falling_ramp();
        bit ok;
        int base;
        ramp_val = 201; ramp_dir = -1; ready_mode = 1'b0;
        trig_rising = 1'b0; trig_threshold = 12'd150; pre_samples = 4'd2; post_samples = 4'd2;
        repeat (10) step();
        push_window(150, -1, 2, 5);
        base = done_cnt;
        arm = 1'b1; step(); arm = 1'b0;
        run_until_done(base, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fall_timeout: got no done, expected done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fall_left: got %0d beats missing, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_sw_trig();
        bit ok;
        int base;
        int t;
        ramp_val = 201; ramp_dir = -1; ready_mode = 1'b0;
        trig_rising = 1'b0; trig_threshold = 12'd4095; pre_samples = 4'd2; post_samples = 4'd2;
        repeat (12) step();
        sw_trig = 1'b1; step(); sw_trig = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL swtrig_idle: got busy=%b, expected 0", busy); end
        base = done_cnt;
        arm = 1'b1; step(); arm = 1'b0;
        repeat (8) step();
        // The sample seen by the trigger logic entered des_data two cycles earlier.
        t = ramp_val - 2 * ramp_dir;
        push_window(t, -1, 2, 5);
        sw_trig = 1'b1; step(); sw_trig = 1'b0;
        run_until_done(base, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL swtrig_timeout: got no done, expected done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL swtrig_left: got %0d beats missing, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit ok;
        int base;
        ramp_val = 0; ramp_dir = 1; ready_mode = 1'b1;
        trig_rising = 1'b1; trig_threshold = 12'd100; pre_samples = 4'd4; post_samples = 4'd3;
        repeat (40) step();
        push_window(100, 1, 4, 8);
        base = done_cnt;
        arm = 1'b1; step(); arm = 1'b0;
        run_until_done(base, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: got no done, expected done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_left: got %0d beats missing, expected 0", exp_q.size()); end
        ready_mode = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_clamp_abort();
        bit ok;
        int base;
        int p;
        int q;
        int len;
        ramp_val = 900; ramp_dir = 1; ready_mode = 1'b0;
        trig_rising = 1'b1; trig_threshold = 12'd4095; pre_samples = 4'd10; post_samples = 4'd10;
        repeat (5) step();
        arm = 1'b1; step(); arm = 1'b0;
        repeat (14) step();
        sw_trig = 1'b1; step(); sw_trig = 1'b0;
        step();
        base = done_cnt;
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if ({busy, m_valid} !== 2'b00) begin errors++; $display("FAIL abort_idle: got busy/valid=%b, expected 00", {busy, m_valid}); end
        repeat (10) step();
        abort = 1'b1; arm = 1'b1; step(); abort = 1'b0; arm = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins: got busy=%b, expected 0", busy); end
        repeat (20) step();
        checks++;
        if (done_cnt != base) begin errors++; $display("FAIL abort_done: got %0d done pulses, expected 0", done_cnt - base); end
        trig_threshold = 12'd1000;
        p = 10; q = 10;
        if (p + q > DEPTH - 1) q = DEPTH - 1 - p;
        len = p + 1 + q;
        push_window(1000, 1, p, len);
        base = done_cnt;
        arm = 1'b1; step(); arm = 1'b0;
        run_until_done(base, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clamp_timeout: got no done, expected done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL clamp_left: got %0d beats missing, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

`ifdef ADC_CAPTURE_TWOS_COMP_EN
    task automatic test_twos_comp();
        bit ok;
        int base;
        beat_t b;
        ramp_val = 12'h7FF; ramp_dir = 0; ready_mode = 1'b0;
        trig_rising = 1'b1; trig_threshold = 12'd0; pre_samples = 4'd1; post_samples = 4'd0;
        repeat (6) step();
        b.d = 12'hFFF; b.l = 1'b0; exp_q.push_back(b);
        b.d = 12'h000; b.l = 1'b1; exp_q.push_back(b);
        base = done_cnt;
        arm = 1'b1; step(); arm = 1'b0;
        repeat (4) step();
        ramp_val = 12'h800;
        run_until_done(base, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL twos_timeout: got no done, expected done"); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL twos_left: got %0d beats missing, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_rising_ramp();
        test_falling_ramp();
        test_sw_trig();
        test_backpressure();
        test_clamp_abort();
`ifdef ADC_CAPTURE_TWOS_COMP_EN
        test_twos_comp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
